serial_mag_comparator: RTL and testbench
========================================

SERIAL_MAG_COMPARATOR -- requirements
Module: serial_mag_comparator

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand width in bits; legal values are even and at least 2; number of slices N = WIDTH/2.
REQ-002 SHALL have port clk, input, 1 bit, single rising-edge clock.
REQ-003 SHALL have port rst_n, input, 1 bit, reset, asynchronous and active-low.
REQ-004 SHALL have port start, input, 1 bit, request to begin a comparison.
REQ-005 SHALL have port op_a, input, WIDTH bits, operand A, unsigned.
REQ-006 SHALL have port op_b, input, WIDTH bits, operand B, unsigned.
REQ-007 SHALL have port slice_a, output, 2 bits, current A slice driven to the downstream 2-bit comparator.
REQ-008 SHALL have port slice_b, output, 2 bits, current B slice driven to the downstream 2-bit comparator.
REQ-009 SHALL have port s_gt, input, 1 bit, slice A>B flag returned combinationally by the 2-bit comparator.
REQ-010 SHALL have port s_lt, input, 1 bit, slice A<B flag.
REQ-011 SHALL have port s_eq, input, 1 bit, slice A==B flag.
REQ-012 SHALL have port busy, output, 1 bit, comparison in progress.
REQ-013 SHALL have port done, output, 1 bit, one-cycle result strobe.
REQ-014 SHALL have port A_gt_B, output, 1 bit, registered word result.
REQ-015 SHALL have port A_lt_B, output, 1 bit, registered word result.
REQ-016 SHALL have port A_eq_B, output, 1 bit, registered word result.
REQ-017 SHALL have port cmp_err, output, 1 bit, slice flags were not one-hot.

Function
REQ-018 SHALL implement a state machine with three states: IDLE, COMPARE and DONE.
REQ-019 SHALL, in IDLE with start=1 at a clock edge, load op_a and op_b into shift registers, clear the slice counter, clear the result outputs and cmp_err, and go to COMPARE.
REQ-020 SHALL ignore start in COMPARE and DONE, with no effect on the operand registers, the counter or the results.
REQ-021 SHALL drive slice_a and slice_b from bits [WIDTH-1:WIDTH-2] of the shift registers, MSB slice first, and drive 2'b00 outside COMPARE.
REQ-022 SHALL sample s_gt, s_lt and s_eq at each COMPARE edge in the same cycle the slice is driven (zero-latency combinational loop through the downstream comparator).
REQ-023 SHALL go to DONE at a COMPARE edge where the flags are not exactly one-hot, setting cmp_err=1 and clearing all three results.
REQ-024 SHALL, at a COMPARE edge with s_gt=1 or s_lt=1, record the first unequal slice as the word result (A_gt_B or A_lt_B); later slices never override it.
REQ-025 SHALL, at a COMPARE edge with s_eq=1 that is not the last slice, shift both registers left by 2 and increment the counter.
REQ-026 SHALL, at the COMPARE edge of the last slice (counter=N-1) with no prior unequal slice, set A_eq_B=1 if s_eq=1, and go to DONE.
REQ-027 SHALL hold busy=1 exactly while in COMPARE.
REQ-028 SHALL hold done=1 for exactly one cycle while in DONE, then return to IDLE unconditionally.
REQ-029 SHALL hold the results and cmp_err from DONE until the next accepted start.
REQ-030 SHALL have exactly one of A_gt_B, A_lt_B, A_eq_B high after any completed comparison with cmp_err=0.

Reset
REQ-031 SHALL, on rst_n=0, immediately force state IDLE, busy=0, done=0, all results 0, cmp_err=0, counter 0 and slices 2'b00, regardless of the clock.
REQ-032 SHALL, on reset asserted mid-COMPARE, abort the comparison without asserting done; the first start after rst_n rises SHALL be accepted normally.

Configuration
REQ-033 SHALL, with macro SERIAL_CMP_EARLY_EXIT_EN defined, go to DONE at the first COMPARE edge with an unequal slice or a flag error, giving latency k compare cycles (k = index of the first unequal slice, 1-based).
REQ-034 SHALL, without SERIAL_CMP_EARLY_EXIT_EN, always spend exactly N compare cycles (except on flag error, which exits immediately), with results identical to early-exit mode.

Verification
REQ-035 SHALL cover: WIDTH=8, op_a=0xB4, op_b=0xB4, start -> busy for 4 cycles, then done with A_eq_B=1 and A_gt_B=A_lt_B=0.
REQ-036 SHALL cover: op_a=0xC0, op_b=0x80 -> A_gt_B=1; done after 1 compare cycle with the macro defined, after 4 without.
REQ-037 SHALL cover: op_a=0x1F, op_b=0x2F -> A_lt_B=1 (first slice 00 vs 00, second slice 01 vs 10); early-exit latency 2 cycles.
REQ-038 SHALL cover: s_gt and s_eq forced to 1 on the first slice -> cmp_err=1, all results 0, done the next cycle.
REQ-039 SHALL cover: rst_n pulled low during the second compare cycle -> all outputs 0 immediately, no done; a new start with 0x00/0xFF then gives A_lt_B=1.
REQ-040 SHALL cover: start held high through COMPARE and DONE -> the operands are not reloaded, and a second comparison is accepted only in the cycle after done.

Source files
------------

// File: rtl/serial_mag_comparator.sv
// serial_mag_comparator: compares two unsigned WIDTH-bit operands two bits at a time, MSB slice
// first, using an external combinational 2-bit comparator.
//
// Ports:
//   clk, rst_n            clock and asynchronous active-low reset
//   start                 begin a comparison (accepted only in IDLE)
//   op_a, op_b            operands, captured on an accepted start
//   slice_a, slice_b      current 2-bit slices to the external comparator (2'b00 outside COMPARE)
//   s_gt, s_lt, s_eq      slice flags returned combinationally by the external comparator
//   busy                  high while in COMPARE
//   done                  one-cycle strobe in DONE
//   A_gt_B, A_lt_B, A_eq_B registered word result, held until the next accepted start
//   cmp_err               slice flags were not one-hot
//
// Build option: define SERIAL_CMP_EARLY_EXIT_EN to finish at the first unequal slice instead of
// always walking all WIDTH/2 slices.

module serial_mag_comparator #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic [1:0]       slice_a,
  output logic [1:0]       slice_b,
  input  logic             s_gt,
  input  logic             s_lt,
  input  logic             s_eq,
  output logic             busy,
  output logic             done,
  output logic             A_gt_B,
  output logic             A_lt_B,
  output logic             A_eq_B,
  output logic             cmp_err
);

  localparam int unsigned N    = WIDTH / 2;
  localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(N - 1);

  typedef enum logic [1:0] {
    StIdle,
    StCompare,
    StDone
  } state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  sh_a_q, sh_a_d;
  logic [WIDTH-1:0]  sh_b_q, sh_b_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              gt_q, gt_d;
  logic              lt_q, lt_d;
  logic              eq_q, eq_d;
  logic              err_q, err_d;
  logic              last_slice;
  logic              flags_ok;
  logic              decided;

  assign last_slice = (cnt_q == LastCnt);
  assign flags_ok   = $onehot({s_gt, s_lt, s_eq});
  // Results are cleared on start, so any set gt/lt means an earlier slice already decided.
  assign decided    = gt_q | lt_q;

  always_comb begin
    state_d = state_q;
    sh_a_d  = sh_a_q;
    sh_b_d  = sh_b_q;
    cnt_d   = cnt_q;
    gt_d    = gt_q;
    lt_d    = lt_q;
    eq_d    = eq_q;
    err_d   = err_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          sh_a_d  = op_a;
          sh_b_d  = op_b;
          cnt_d   = '0;
          gt_d    = 1'b0;
          lt_d    = 1'b0;
          eq_d    = 1'b0;
          err_d   = 1'b0;
          state_d = StCompare;
        end
      end

      StCompare: begin
        if (!flags_ok) begin
          err_d   = 1'b1;
          gt_d    = 1'b0;
          lt_d    = 1'b0;
          eq_d    = 1'b0;
          state_d = StDone;
        end else begin
          // First unequal slice wins; later slices only advance the walk.
          if (!decided) begin
            gt_d = s_gt;
            lt_d = s_lt;
            if (last_slice) begin
              eq_d = s_eq;
            end
          end
`ifdef SERIAL_CMP_EARLY_EXIT_EN
          if (!s_eq || last_slice) begin
            state_d = StDone;
          end else begin
            sh_a_d = sh_a_q << 2;
            sh_b_d = sh_b_q << 2;
            cnt_d  = cnt_q + 1'b1;
          end
`else
          if (last_slice) begin
            state_d = StDone;
          end else begin
            sh_a_d = sh_a_q << 2;
            sh_b_d = sh_b_q << 2;
            cnt_d  = cnt_q + 1'b1;
          end
`endif
        end
      end

      StDone: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      sh_a_q  <= '0;
      sh_b_q  <= '0;
      cnt_q   <= '0;
      gt_q    <= 1'b0;
      lt_q    <= 1'b0;
      eq_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_a_q  <= sh_a_d;
      sh_b_q  <= sh_b_d;
      cnt_q   <= cnt_d;
      gt_q    <= gt_d;
      lt_q    <= lt_d;
      eq_q    <= eq_d;
      err_q   <= err_d;
    end
  end

  assign busy    = (state_q == StCompare);
  assign done    = (state_q == StDone);
  assign slice_a = busy ? sh_a_q[WIDTH-1:WIDTH-2] : 2'b00;
  assign slice_b = busy ? sh_b_q[WIDTH-1:WIDTH-2] : 2'b00;
  assign A_gt_B  = gt_q;
  assign A_lt_B  = lt_q;
  assign A_eq_B  = eq_q;
  assign cmp_err = err_q;

endmodule

// File: tb/tb_serial_mag_comparator.sv
// tb_serial_mag_comparator: directed self-checking bench for serial_mag_comparator (WIDTH=8).
// Models the downstream 2-bit comparator, with an override to inject non-one-hot flags.

module tb_serial_mag_comparator;

`ifdef SERIAL_CMP_EARLY_EXIT_EN
  localparam bit Early = 1'b1;
`else
  localparam bit Early = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic [7:0] op_a = 8'h00;
  logic [7:0] op_b = 8'h00;
  logic [1:0] slice_a, slice_b;
  logic       s_gt, s_lt, s_eq;
  logic       busy, done, A_gt_B, A_lt_B, A_eq_B, cmp_err;
  logic       frc = 1'b0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Downstream 2-bit comparator; frc drives an illegal gt+eq pattern.
  assign s_gt = frc ? 1'b1 : (slice_a > slice_b);
  assign s_lt = frc ? 1'b0 : (slice_a < slice_b);
  assign s_eq = frc ? 1'b1 : (slice_a == slice_b);

  serial_mag_comparator #(.WIDTH(8)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .op_a    (op_a),
    .op_b    (op_b),
    .slice_a (slice_a),
    .slice_b (slice_b),
    .s_gt    (s_gt),
    .s_lt    (s_lt),
    .s_eq    (s_eq),
    .busy    (busy),
    .done    (done),
    .A_gt_B  (A_gt_B),
    .A_lt_B  (A_lt_B),
    .A_eq_B  (A_eq_B),
    .cmp_err (cmp_err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issues one start pulse, then counts busy cycles until done (bounded).
  task automatic run_cmp(input logic [7:0] a, input logic [7:0] b, output int lat,
                         output logic [3:0] first_slices, output logic got_done);
    op_a = a;
    op_b = b;
    start = 1'b1;
    step();
    start = 1'b0;
    first_slices = {slice_a, slice_b};
    lat = 0;
    got_done = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (done) begin
        got_done = 1'b1;
        break;
      end
      if (busy) lat++;
      step();
    end
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, A_gt_B, A_lt_B, A_eq_B, cmp_err, slice_a, slice_b} !== 10'b0) begin
      failures++;
      $display("FAIL reset_outputs: got %b, want 0", {busy, done, A_gt_B, A_lt_B, A_eq_B,
               cmp_err, slice_a, slice_b});
    end
    step();
    step();
    rst_n = 1'b1;
    step();
    checks++;
    if ({busy, done} !== 2'b00) begin
      failures++;
      $display("FAIL reset_idle: busy/done got %b, want 00", {busy, done});
    end
  endtask

  task automatic test_equal();
    int lat;
    logic [3:0] fs;
    logic ok;
    run_cmp(8'hB4, 8'hB4, lat, fs, ok);
    checks++;
    if (ok !== 1'b1) begin
      failures++;
      $display("FAIL eq_timeout: done got %b, want 1", ok);
    end
    checks++;
    if (fs !== 4'b1010) begin
      failures++;
      $display("FAIL eq_first_slice: got %b, want 1010", fs);
    end
    checks++;
    if (lat !== 4) begin
      failures++;
      $display("FAIL eq_latency: got %0d, want 4", lat);
    end
    checks++;
    if ({A_gt_B, A_lt_B, A_eq_B, cmp_err, busy} !== 5'b00100) begin
      failures++;
      $display("FAIL eq_result: gt/lt/eq/err/busy got %b, want 00100",
               {A_gt_B, A_lt_B, A_eq_B, cmp_err, busy});
    end
    step();
    checks++;
    if ({done, A_gt_B, A_lt_B, A_eq_B, slice_a} !== 6'b000100) begin
      failures++;
      $display("FAIL eq_after_done: done/gt/lt/eq/slice_a got %b, want 000100",
               {done, A_gt_B, A_lt_B, A_eq_B, slice_a});
    end
  endtask

  task automatic test_greater();
    int lat;
    logic [3:0] fs;
    logic ok;
    run_cmp(8'hC0, 8'h80, lat, fs, ok);
    checks++;
    if (ok !== 1'b1 || lat !== (Early ? 1 : 4)) begin
      failures++;
      $display("FAIL gt_latency: got done=%b lat=%0d, want done=1 lat=%0d", ok, lat,
               Early ? 1 : 4);
    end
    checks++;
    if ({A_gt_B, A_lt_B, A_eq_B, cmp_err} !== 4'b1000) begin
      failures++;
      $display("FAIL gt_result: gt/lt/eq/err got %b, want 1000",
               {A_gt_B, A_lt_B, A_eq_B, cmp_err});
    end
    step();
  endtask

  task automatic test_less();
    int lat;
    logic [3:0] fs;
    logic ok;
    run_cmp(8'h1F, 8'h2F, lat, fs, ok);
    checks++;
    if (ok !== 1'b1 || lat !== (Early ? 2 : 4)) begin
      failures++;
      $display("FAIL lt_latency: got done=%b lat=%0d, want done=1 lat=%0d", ok, lat,
               Early ? 2 : 4);
    end
    checks++;
    if ({A_gt_B, A_lt_B, A_eq_B, cmp_err} !== 4'b0100) begin
      failures++;
      $display("FAIL lt_result: gt/lt/eq/err got %b, want 0100",
               {A_gt_B, A_lt_B, A_eq_B, cmp_err});
    end
    step();
  endtask

  task automatic test_flag_error();
    op_a = 8'h55;
    op_b = 8'h55;
    start = 1'b1;
    step();
    start = 1'b0;
    frc = 1'b1;
    step();
    frc = 1'b0;
    checks++;
    if ({done, busy} !== 2'b10) begin
      failures++;
      $display("FAIL err_done: done/busy got %b, want 10", {done, busy});
    end
    checks++;
    if ({cmp_err, A_gt_B, A_lt_B, A_eq_B} !== 4'b1000) begin
      failures++;
      $display("FAIL err_result: err/gt/lt/eq got %b, want 1000",
               {cmp_err, A_gt_B, A_lt_B, A_eq_B});
    end
    step();
    checks++;
    if ({done, cmp_err} !== 2'b01) begin
      failures++;
      $display("FAIL err_hold: done/err got %b, want 01", {done, cmp_err});
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    logic [3:0] fs;
    logic ok;
    logic saw_done;
    op_a = 8'h55;
    op_b = 8'h55;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL rstmid_busy: got %b, want 1", busy);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, A_gt_B, A_lt_B, A_eq_B, cmp_err, slice_a, slice_b} !== 10'b0) begin
      failures++;
      $display("FAIL rstmid_outputs: got %b, want 0", {busy, done, A_gt_B, A_lt_B, A_eq_B,
               cmp_err, slice_a, slice_b});
    end
    saw_done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (done) saw_done = 1'b1;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      if (done) saw_done = 1'b1;
    end
    checks++;
    if (saw_done !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_no_done: got %b, want 0", saw_done);
    end
    run_cmp(8'h00, 8'hFF, lat, fs, ok);
    checks++;
    if (ok !== 1'b1 || lat !== (Early ? 1 : 4)) begin
      failures++;
      $display("FAIL rstmid_latency: got done=%b lat=%0d, want done=1 lat=%0d", ok, lat,
               Early ? 1 : 4);
    end
    checks++;
    if ({A_gt_B, A_lt_B, A_eq_B, cmp_err} !== 4'b0100) begin
      failures++;
      $display("FAIL rstmid_result: gt/lt/eq/err got %b, want 0100",
               {A_gt_B, A_lt_B, A_eq_B, cmp_err});
    end
    step();
  endtask

  task automatic test_back_to_back();
    int lat;
    logic ok;
    op_a = 8'hC0;
    op_b = 8'h80;
    start = 1'b1;
    step();
    // Start stays high; new operands must not be picked up until after done.
    op_a = 8'h00;
    op_b = 8'hFF;
    lat = 0;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (done) begin
        ok = 1'b1;
        break;
      end
      if (busy) lat++;
      step();
    end
    checks++;
    if (ok !== 1'b1 || lat !== (Early ? 1 : 4)) begin
      failures++;
      $display("FAIL b2b_latency: got done=%b lat=%0d, want done=1 lat=%0d", ok, lat,
               Early ? 1 : 4);
    end
    checks++;
    if ({A_gt_B, A_lt_B, A_eq_B} !== 3'b100) begin
      failures++;
      $display("FAIL b2b_no_reload: gt/lt/eq got %b, want 100", {A_gt_B, A_lt_B, A_eq_B});
    end
    step();
    checks++;
    if ({busy, done, A_gt_B} !== 3'b001) begin
      failures++;
      $display("FAIL b2b_idle_after_done: busy/done/gt got %b, want 001",
               {busy, done, A_gt_B});
    end
    step();
    checks++;
    if ({busy, A_gt_B, A_lt_B, slice_a, slice_b} !== 7'b1000011) begin
      failures++;
      $display("FAIL b2b_second_accept: busy/gt/lt/sa/sb got %b, want 1000011",
               {busy, A_gt_B, A_lt_B, slice_a, slice_b});
    end
    start = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (done) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    checks++;
    if (ok !== 1'b1 || {A_gt_B, A_lt_B, A_eq_B} !== 3'b010) begin
      failures++;
      $display("FAIL b2b_second_result: done=%b gt/lt/eq=%b, want done=1 010", ok,
               {A_gt_B, A_lt_B, A_eq_B});
    end
    step();
  endtask

  initial begin
    test_reset();
    test_equal();
    test_greater();
    test_less();
    test_flag_error();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
